ssd_display_driver: RTL
=======================

// Module: ssd_display_driver
// PURPOSE
// - Consumes the 13-bit ssd value produced by the Datapath (0..8191) and drives a 4-digit
//   multiplexed seven-segment display with decimal digits; sits between Datapath and board pins.
// - Sequential shift-add-3 binary-to-BCD converter, refresh counter for digit multiplexing,
//   registered active-low anode/cathode outputs, optional leading-zero blanking.
// PARAMETERS
// - REFRESH_BITS  18  refresh counter width; each digit lit 2^(REFRESH_BITS-2) cycles (bench: 4)
// - BLANK_LZ      1   1 = blank leading zero digits (ones digit always shown); 0 = show all 4
// PORTS
// - clk        in   1   system clock, all state on rising edge
// - Reset      in   1   synchronous, active-high reset
// - num        in   13  unsigned binary value to display (Datapath ssd output)
// - anode      out  4   digit enables, active-low; anode[0] = ones digit ... anode[3] = thousands
// - cathode    out  7   segments {g,f,e,d,c,b,a}, active-low
// - bcd_valid  out  1   1 once the first conversion since reset has completed
// BEHAVIOUR
// - Reset (sampled on clk edge): anode=4'b1111, cathode=7'b1111111, bcd_valid=0, refresh
//   counter=0, display BCD register=0, FSM=IDLE, pending=1. Applies mid-conversion: abort, no
//   partial result reaches display register.
// - FSM states IDLE, CONVERT, DONE:
//   IDLE: if pending or num != num_last -> latch num into num_last and shift reg {16'b0,num},
//     iteration count=13, clear pending, go CONVERT. Else stay.
//   CONVERT: each cycle, every BCD nibble >= 5 gets +3, then whole reg shifts left 1;
//     count decrements; after 13th shift go DONE.
//   DONE: copy 16-bit BCD (4 nibbles) into display register, bcd_valid<=1, go IDLE.
// - Latency: num sampled in IDLE cycle T; display register updated at edge T+14; outputs reflect
//   new digit at next refresh-slot update (registered, +1 cycle after select).
// - num changing during CONVERT/DONE is ignored for that conversion; IDLE re-compares and starts a
//   new conversion the cycle after DONE. Display register never holds a torn/partial value.
// - Max 8191 -> BCD 8,1,9,1; no overflow possible (16 BCD bits >= 13 binary bits + 3).
// - Refresh counter: REFRESH_BITS wide, free-running, wraps 2^N-1 -> 0; sel = top 2 bits.
//   Each cycle: anode <= ~(4'b0001 << sel); cathode <= seg(digit[sel]).
// - Before bcd_valid=1: anode held 4'b1111, cathode 7'b1111111.
// - Blanking (BLANK_LZ=1): digit k>0 blanked (anode bit 1, cathode all 1) when it and all higher
//   digits are 0. Value 0 shows single '0' on ones digit.
// - Segment codes (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; any other nibble = 1111111.
// TESTING
// - All runs REFRESH_BITS=4 (4 cycles/digit), Reset high 2 cycles then low.
// - num=1234 -> bcd_valid=1 within 15 cycles of Reset low; then cycling anode/cathode:
//   1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001, repeating every 16 cycles.
// - num=8191 -> slots show 1 (1111001), 9 (0010000), 1 (1111001), 8 (0000000) for anode 1110..0111.
// - BLANK_LZ=1, num=7 -> anode 1110 with 1111000; other three slots anode 1111, cathode 1111111.
//   num=0 -> ones slot 1000000, others blank. BLANK_LZ=0, num=7 -> 0,0,0 on upper digits.
// - num=1234 then 5678 at 5th CONVERT cycle -> display shows 1234 first, then 5678 within 15
//   cycles after that DONE; no other digit pattern ever appears.
// - Reset asserted mid-CONVERT (num=4321) -> next cycle anode=1111, bcd_valid=0; after release,
//   4321 shown within 15 cycles; refresh sequence restarts from anode 1110.

Source files
------------

// File: rtl/ssd_display_driver_if.sv
// Bundle between the Datapath (master) and the seven-segment driver (slave).
// The Datapath drives num. The driver returns the pin-level anode/cathode and bcd_valid.
interface ssd_display_driver_if;
  logic [12:0] num;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        bcd_valid;

  modport master (output num, input anode, cathode, bcd_valid);
  modport slave  (input num, output anode, cathode, bcd_valid);
endinterface

// File: rtl/ssd_display_driver.sv
// Four-digit multiplexed seven-segment driver.
// A sequential shift-add-3 converter turns the 13-bit binary value into BCD, and a free-running refresh counter scans the digits.
module ssd_display_driver #(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input logic                 clk,
  input logic                 Reset,
  ssd_display_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_r;
  logic [28:0]             shift_r;
  logic [3:0]              count_r;
  logic [12:0]             num_last_r;
  logic                    pending_r;
  logic [15:0]             disp_r;
  logic                    bcd_valid_r;
  logic [REFRESH_BITS-1:0] refresh_r;
  logic [3:0]              anode_r;
  logic [6:0]              cathode_r;

  logic [28:0]             adj_s;
  logic [1:0]              sel_s;
  logic [3:0]              digit_s;
  logic                    blank_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // Add-3 correction on every BCD nibble before the next shift
  always_comb begin
    adj_s        = shift_r;
    adj_s[28:25] = add3(shift_r[28:25]);
    adj_s[24:21] = add3(shift_r[24:21]);
    adj_s[20:17] = add3(shift_r[20:17]);
    adj_s[16:13] = add3(shift_r[16:13]);
  end

  // Digit selection and leading-zero blanking for the current refresh slot
  always_comb begin
    sel_s = refresh_r[REFRESH_BITS-1 -: 2];
    case (sel_s)
      2'd0: begin
        digit_s = disp_r[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        digit_s = disp_r[7:4];
        blank_s = BLANK_LZ && (disp_r[15:4] == 12'd0);
      end
      2'd2: begin
        digit_s = disp_r[11:8];
        blank_s = BLANK_LZ && (disp_r[15:8] == 8'd0);
      end
      2'd3: begin
        digit_s = disp_r[15:12];
        blank_s = BLANK_LZ && (disp_r[15:12] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
      end
    endcase
  end

  // Conversion FSM: the display register is written only in DONE, so it never holds a partial result
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      shift_r     <= 29'd0;
      count_r     <= 4'd0;
      num_last_r  <= 13'd0;
      pending_r   <= 1'b1;
      disp_r      <= 16'd0;
      bcd_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pending_r || (bus.num != num_last_r)) begin
            num_last_r <= bus.num;
            shift_r    <= {16'd0, bus.num};
            count_r    <= 4'd13;
            pending_r  <= 1'b0;
            state_r    <= CONVERT;
          end else begin
            state_r    <= IDLE;
          end
        end
        CONVERT: begin
          shift_r <= adj_s << 5'd1;
          count_r <= count_r - 4'd1;
          if (count_r == 4'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= CONVERT;
          end
        end
        DONE: begin
          disp_r      <= shift_r[28:13];
          bcd_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Refresh scan and registered active-low pin drivers
  always_ff @(posedge clk) begin
    if (Reset) begin
      refresh_r <= {REFRESH_BITS{1'b0}};
      anode_r   <= 4'b1111;
      cathode_r <= 7'b1111111;
    end else begin
      refresh_r <= refresh_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      if (!bcd_valid_r || blank_s) begin
        anode_r   <= 4'b1111;
        cathode_r <= 7'b1111111;
      end else begin
        anode_r   <= ~(4'b0001 << sel_s);
        cathode_r <= seg_decode(digit_s);
      end
    end
  end

  assign bus.anode     = anode_r;
  assign bus.cathode   = cathode_r;
  assign bus.bcd_valid = bcd_valid_r;

endmodule
